// File: rtl/peasant_divider.sv
// peasant_divider: 32/16 unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a division (sampled only while ready=1)
//   dividend   32-bit unsigned numerator, latched on accept
//   divisor    16-bit unsigned denominator, latched on accept
//   ready      high in IDLE
//   busy       high in RUN
//   done       one-cycle pulse in the DONE cycle, when results update
//   quotient   registered 32-bit quotient
//   remainder  registered 16-bit remainder
//   div_err    registered divide-by-zero flag (only with DIV_ZERO_ERR_EN)
//
// Configuration macro: DIV_ZERO_ERR_EN adds the div_err output.
// A zero divisor skips RUN: quotient=all ones, remainder=dividend[15:0].

module peasant_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [15:0] remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic        div_err
`endif
);

    localparam int unsigned DW = 32;
    localparam int unsigned VW = 16;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // dq_q shifts the dividend out of its top and the quotient bits in at the bottom
    logic [DW-1:0] dq_q;
    logic [VW-1:0] dvs_q;
    logic [VW-1:0] pr_q;
    logic [CW-1:0] cnt_q;

    logic [VW:0]   pr_sh;
    logic [VW:0]   diff;
    logic          ge;
    logic [VW-1:0] pr_step;
    logic [DW-1:0] dq_step;
    logic          last;
    logic          accept;
    logic          div_zero;

    // One restoring step. The 17-bit shifted partial remainder is < 2*divisor,
    // so bit 16 of the difference is set exactly when it is below the divisor.
    always_comb begin
        pr_sh    = {pr_q, dq_q[DW-1]};
        diff     = pr_sh - {1'b0, dvs_q};
        ge       = ~diff[VW];
        pr_step  = ge ? diff[VW-1:0] : pr_sh[VW-1:0];
        dq_step  = {dq_q[DW-2:0], ge};
        last     = (cnt_q == CW'(DW - 1));
        accept   = (state_q == S_IDLE) && start;
        div_zero = (divisor == '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath and result registers; results load on the edge into DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_q      <= '0;
            dvs_q     <= '0;
            pr_q      <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_ERR_EN
            div_err   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                dq_q  <= dividend;
                dvs_q <= divisor;
                pr_q  <= '0;
                cnt_q <= '0;
                if (div_zero) begin
                    quotient  <= '1;
                    remainder <= dividend[VW-1:0];
`ifdef DIV_ZERO_ERR_EN
                    div_err   <= 1'b1;
`endif
                end
            end else if (state_q == S_RUN) begin
                dq_q  <= dq_step;
                pr_q  <= pr_step;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    quotient  <= dq_step;
                    remainder <= pr_step;
`ifdef DIV_ZERO_ERR_EN
                    div_err   <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_peasant_divider.sv
// tb_peasant_divider: vector table, corner sequences and random divisions
// against an arithmetic reference model.

module tb_peasant_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
`ifdef DIV_ZERO_ERR_EN
    logic        div_err;
`endif

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;
    logic [31:0] prev_q = '0;
    logic [15:0] prev_r = '0;

    peasant_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
        ,
        .div_err   (div_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [31:0] q;
        logic [15:0] r;
        logic        err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [15:0] b,
                         output logic [31:0] q, output logic [15:0] r, output logic e);
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
            e = 1'b1;
        end else begin
            q = a / 32'(b);
            r = 16'(a % 32'(b));
            e = 1'b0;
        end
    endtask

    task automatic chk_err(input string nm, input logic e);
`ifdef DIV_ZERO_ERR_EN
        chk(nm, 32'(div_err), 32'(e));
`else
        if (e === 1'bx) $display("unused %s", nm);
`endif
    endtask

    // Call at #1 after a posedge. Starts one division and checks timing and results.
    task automatic run_div(input logic [31:0] dvd, input logic [15:0] dvs,
                           input logic [31:0] eq, input logic [15:0] er,
                           input logic eerr, input string tag);
        int guard;
        int lat;
        int exp_lat;
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, " ready_before_start"}, 32'(ready), 32'd1);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        exp_lat  = (dvs == 16'd0) ? 1 : 33;
        lat      = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (done === 1'b1) begin
                lat = k;
            end else begin
                chk({tag, " busy"}, 32'(busy), 32'(k <= 32));
                chk({tag, " q_hold"}, quotient, prev_q);
                chk({tag, " r_hold"}, 32'(remainder), 32'(prev_r));
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk_err({tag, " div_err"}, eerr);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [31:0] a, mq;
        logic [15:0] b, mr;
        logic        me;
        int          ndone;
        int          dp;

        tbl[0] = '{32'd100,        16'd7,      32'd14,         16'd2,      1'b0};
        tbl[1] = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0};
        tbl[2] = '{32'd3,          16'hFFFF,   32'd0,          16'd3,      1'b0};
        tbl[3] = '{32'h0001_2345,  16'd0,      32'hFFFF_FFFF,  16'h2345,   1'b1};
        tbl[4] = '{32'd10,         16'd5,      32'd2,          16'd0,      1'b0};
        tbl[5] = '{32'd500,        16'd9,      32'd55,         16'd5,      1'b0};
        tbl[6] = '{32'd0,          16'd1,      32'd0,          16'd0,      1'b0};
        tbl[7] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk_err("reset div_err", 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_div(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].err,
                    $sformatf("vec%0d", i));
        end

        // start held high with changing operands during a 1000/3 run
        @(posedge clk); #1;
        chk("held ready", 32'(ready), 32'd1);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd3;
        @(posedge clk); #1;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (done === 1'b1) begin
                ndone++;
                chk("held done_cycle", 32'(k), 32'd33);
                chk("held quotient", quotient, 32'd333);
                chk("held remainder", 32'(remainder), 32'd1);
            end else if (k <= 32) begin
                chk("held busy", 32'(busy), 32'd1);
                chk("held q_hold", quotient, prev_q);
            end else begin
                chk("held q_after", quotient, 32'd333);
                chk("held r_after", 32'(remainder), 32'd1);
                chk("held idle", 32'(ready), 32'd1);
            end
            if (k < 33) begin
                dividend = $urandom;
                divisor  = 16'($urandom_range(1, 65535));
            end else begin
                start = 1'b0;
            end
        end
        chk("held done_count", 32'(ndone), 32'd1);
        prev_q = 32'd333;
        prev_r = 16'd1;

        // asynchronous reset in RUN cycle 10 of 500/9
        start    = 1'b1;
        dividend = 32'd500;
        divisor  = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        dp    = done_pulses;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid ready", 32'(ready), 32'd1);
        chk("rst_mid busy0", 32'(busy), 32'd0);
        chk("rst_mid done", 32'(done), 32'd0);
        chk("rst_mid quotient", quotient, 32'd0);
        chk("rst_mid remainder", 32'(remainder), 32'd0);
        chk_err("rst_mid div_err", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid no_done", 32'(done_pulses), 32'(dp));
        prev_q = '0;
        prev_r = '0;
        run_div(32'd500, 16'd9, 32'd55, 16'd5, 1'b0, "post_rst");

        // random divisions against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 70000));
            model(a, b, mq, mr, me);
            run_div(a, b, mq, mr, me, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
